// File: rtl/pca_fit_pkg.sv
// Shared types and address arithmetic for the PCA track fitter and its coefficient loader.
// Latency: none (declarations and constant functions only).
// Backpressure: not applicable.
package pca_fit_pkg;

   typedef enum logic [1:0] {
      AX_X = 2'd0,
      AX_Y = 2'd1,
      AX_Z = 2'd2
   } axis_e;

   localparam int N_LAYERS_DEF = 6;

   // Accumulator width large enough that 3*N_LAYERS products plus the offset never overflow.
   function automatic int acc_width(input int coord_w, input int coef_w, input int n_layers);
      return coord_w + coef_w + $clog2(3 * n_layers + 1) + 1;
   endfunction

   function automatic int addr_width(input int n_params, input int n_layers);
      return $clog2(n_params * (3 * n_layers + 1));
   endfunction

   // Each parameter owns a block of 3*N_LAYERS coefficients followed by its offset.
   function automatic int coef_addr(input int k, input int l, input axis_e ax,
                                    input int n_layers = N_LAYERS_DEF);
      return k * (3 * n_layers + 1) + 3 * l + int'(ax);
   endfunction

   function automatic int offset_addr(input int k, input int n_layers = N_LAYERS_DEF);
      return k * (3 * n_layers + 1) + 3 * n_layers;
   endfunction

endpackage

// File: rtl/pca_coef_bank.sv
// Writable coefficient/offset bank with range-checked writes and per-layer parallel fan-out.
// Latency: write lands at the strobe edge; read data one cycle after the strobe; fan-out combinational.
// Backpressure: none; writes while the fitter is busy or out of range are dropped and flagged sticky.
module pca_coef_bank
   import pca_fit_pkg::*;
#(
   parameter  int N_LAYERS = 6,
   parameter  int N_PARAMS = 2,
   parameter  int COEF_W   = 8,
   localparam int ADDR_W   = addr_width(N_PARAMS, N_LAYERS),
   localparam int LAYER_W  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mem_en,
   input  logic               mem_rd_wr,
   input  logic [ADDR_W-1:0]  mem_add,
   input  logic [COEF_W-1:0]  mem_data,
   input  logic               busy,
   input  logic [LAYER_W-1:0] layer,
   output logic [COEF_W-1:0]  mem_rdata,
   output logic               mem_rvalid,
   output logic               cfg_err,
   output logic [COEF_W-1:0]  coef [N_PARAMS][3],
   output logic [COEF_W-1:0]  offset [N_PARAMS]
);

   localparam int N_ENT = N_PARAMS * (3 * N_LAYERS + 1);

   logic [COEF_W-1:0] bank [N_ENT];
   logic              in_range;

   assign in_range = (int'(mem_add) < N_ENT);

   // Config port: gated writes, registered reads, sticky error on any rejected write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_ENT; i++) bank[i] <= '0;
         mem_rdata  <= '0;
         mem_rvalid <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         mem_rvalid <= mem_en & ~mem_rd_wr;
         if (mem_en & ~mem_rd_wr)
            mem_rdata <= in_range ? bank[mem_add] : '0;
         if (mem_en & mem_rd_wr) begin
            if (in_range & ~busy) bank[mem_add] <= mem_data;
            else                  cfg_err       <= 1'b1;
         end
      end
   end

   // Present the x/y/z coefficients of the current layer and every offset to all parameter MACs.
   always_comb begin
      for (int k = 0; k < N_PARAMS; k++) begin
         coef[k][0] = bank[ADDR_W'(coef_addr(k, int'(layer), AX_X, N_LAYERS))];
         coef[k][1] = bank[ADDR_W'(coef_addr(k, int'(layer), AX_Y, N_LAYERS))];
         coef[k][2] = bank[ADDR_W'(coef_addr(k, int'(layer), AX_Z, N_LAYERS))];
         offset[k]  = bank[ADDR_W'(offset_addr(k, N_LAYERS))];
      end
   end

endmodule

// File: rtl/pca_track_fitter.sv
// PCA linear track fitter: accumulates N_LAYERS hits and emits N_PARAMS saturated parameters serially.
// Latency: last hit in cycle T -> parameter k valid in cycle T+3+k.
// Backpressure: none; hits accepted every cycle, drain always finishes before the next track's results.
module pca_track_fitter
   import pca_fit_pkg::*;
#(
   parameter  int N_LAYERS = 6,
   parameter  int N_PARAMS = 2,
   parameter  int COORD_W  = 8,
   parameter  int COEF_W   = 8,
   parameter  int OUT_W    = 16,
   parameter  int SHIFT    = 0,
   localparam int ADDR_W   = addr_width(N_PARAMS, N_LAYERS),
   localparam int IDX_W    = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      dv_in,
   input  logic signed [COORD_W-1:0] data_in_x,
   input  logic signed [COORD_W-1:0] data_in_y,
   input  logic signed [COORD_W-1:0] data_in_z,
   input  logic                      mem_en,
   input  logic                      mem_rd_wr,
   input  logic [ADDR_W-1:0]         mem_add,
   input  logic [COEF_W-1:0]         mem_data,
   output logic [COEF_W-1:0]         mem_rdata,
   output logic                      mem_rvalid,
   output logic                      dv_out,
   output logic signed [OUT_W-1:0]   data_out,
   output logic [IDX_W-1:0]          param_idx,
   output logic                      busy,
   output logic                      cfg_err
);

   localparam int ACC_W   = acc_width(COORD_W, COEF_W, N_LAYERS);
   localparam int LAYER_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
   // Saturation bounds as ACC_W-wide patterns 0..01..1 and 1..10..0 (ACC_W always exceeds OUT_W here).
   localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   logic [LAYER_W-1:0]      layer_cnt;
   logic                    first_hit, last_hit;
   logic [COEF_W-1:0]       coef [N_PARAMS][3];
   logic [COEF_W-1:0]       offset [N_PARAMS];
   logic signed [ACC_W-1:0] term [N_PARAMS];
   logic signed [ACC_W-1:0] s1_term [N_PARAMS];
   logic                    s1_vld, s1_first, s1_last;
   logic signed [ACC_W-1:0] acc [N_PARAMS];
   logic                    s2_vld, s2_last;
   logic signed [ACC_W-1:0] obuf [N_PARAMS];
   logic                    drain_act;
   logic [IDX_W-1:0]        drain_idx;

   function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      s = a >>> SHIFT;
      if (s > SAT_HI) return SAT_HI[OUT_W-1:0];
      if (s < SAT_LO) return SAT_LO[OUT_W-1:0];
      return s[OUT_W-1:0];
   endfunction

   assign first_hit = (layer_cnt == '0);
   assign last_hit  = (layer_cnt == LAYER_W'(N_LAYERS - 1));
   assign busy      = (layer_cnt != '0) | s1_vld | s2_vld | drain_act | dv_out;

   pca_coef_bank #(
      .N_LAYERS (N_LAYERS),
      .N_PARAMS (N_PARAMS),
      .COEF_W   (COEF_W)
   ) u_bank (
      .clk        (clk),
      .reset      (reset),
      .mem_en     (mem_en),
      .mem_rd_wr  (mem_rd_wr),
      .mem_add    (mem_add),
      .mem_data   (mem_data),
      .busy       (busy),
      .layer      (layer_cnt),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .cfg_err    (cfg_err),
      .coef       (coef),
      .offset     (offset)
   );

   // Weighted sum of the incoming hit per parameter, with the offset folded in on a track's first hit.
   always_comb begin
      for (int k = 0; k < N_PARAMS; k++) begin
         term[k] = ACC_W'(data_in_x) * ACC_W'($signed(coef[k][0]))
                 + ACC_W'(data_in_y) * ACC_W'($signed(coef[k][1]))
                 + ACC_W'(data_in_z) * ACC_W'($signed(coef[k][2]));
         if (first_hit) term[k] = term[k] + ACC_W'($signed(offset[k]));
      end
   end

   // S1: register the hit's contribution (using coefficients as they are at sampling) and advance the layer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         layer_cnt <= '0;
         s1_vld    <= 1'b0;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
         for (int k = 0; k < N_PARAMS; k++) s1_term[k] <= '0;
      end else begin
         s1_vld <= dv_in;
         if (dv_in) begin
            s1_first  <= first_hit;
            s1_last   <= last_hit;
            layer_cnt <= last_hit ? '0 : layer_cnt + 1'b1;
            for (int k = 0; k < N_PARAMS; k++) s1_term[k] <= term[k];
         end
      end
   end

   // S2: accumulate; a track's first hit overwrites so no clear cycle is needed between tracks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_vld  <= 1'b0;
         s2_last <= 1'b0;
         for (int k = 0; k < N_PARAMS; k++) acc[k] <= '0;
      end else begin
         s2_vld  <= s1_vld;
         s2_last <= s1_vld & s1_last;
         if (s1_vld)
            for (int k = 0; k < N_PARAMS; k++) acc[k] <= s1_first ? s1_term[k] : acc[k] + s1_term[k];
      end
   end

   // Output: snapshot finished sums, drive parameter 0 immediately, then walk the rest one per cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drain_act <= 1'b0;
         drain_idx <= '0;
         dv_out    <= 1'b0;
         data_out  <= '0;
         param_idx <= '0;
         for (int k = 0; k < N_PARAMS; k++) obuf[k] <= '0;
      end else begin
         dv_out <= 1'b0;
         if (s2_last) begin
            for (int k = 0; k < N_PARAMS; k++) obuf[k] <= acc[k];
            data_out  <= sat(acc[0]);
            param_idx <= '0;
            dv_out    <= 1'b1;
            drain_act <= (N_PARAMS > 1);
            drain_idx <= IDX_W'(1);
         end else if (drain_act) begin
            data_out  <= sat(obuf[drain_idx]);
            param_idx <= drain_idx;
            dv_out    <= 1'b1;
            if (drain_idx == IDX_W'(N_PARAMS - 1)) drain_act <= 1'b0;
            else                                   drain_idx <= drain_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pca_track_fitter.sv
module tb_pca_track_fitter;
   import pca_fit_pkg::*;

   localparam int NL = 6;
   localparam int NP = 2;
   localparam int CW = 8;
   localparam int KW = 8;
   localparam int OW = 16;
   localparam int SH = 0;
   localparam int AW = addr_width(NP, NL);
   localparam int NE = NP * (3 * NL + 1);
   localparam longint OUT_HI = (longint'(1) << (OW - 1)) - 1;
   localparam longint OUT_LO = -(longint'(1) << (OW - 1));

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 dv_in = 1'b0;
   logic signed [CW-1:0] data_in_x = '0, data_in_y = '0, data_in_z = '0;
   logic                 mem_en = 1'b0, mem_rd_wr = 1'b0;
   logic [AW-1:0]        mem_add = '0;
   logic [KW-1:0]        mem_data = '0;
   logic [KW-1:0]        mem_rdata;
   logic                 mem_rvalid, dv_out, busy, cfg_err;
   logic signed [OW-1:0] data_out;
   logic [0:0]           param_idx;

   pca_track_fitter dut (
      .clk(clk), .reset(reset), .dv_in(dv_in),
      .data_in_x(data_in_x), .data_in_y(data_in_y), .data_in_z(data_in_z),
      .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_add(mem_add), .mem_data(mem_data),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .dv_out(dv_out), .data_out(data_out),
      .param_idx(param_idx), .busy(busy), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state
   int      total = 0, bad = 0;
   longint  bank_m [NE];
   longint  acc_m [NP];
   int      cnt_m, last_hit_cyc, last_fin_cyc;
   bit      err_m, busy_snap, rd_pend;
   logic [KW-1:0] rd_exp;
   typedef struct { int c; int k; longint v; } exp_t;
   exp_t    exp_q[$];
   exp_t    e;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic longint sat_m(input longint a);
      longint s = a >>> SH;
      if (s > OUT_HI) return OUT_HI;
      if (s < OUT_LO) return OUT_LO;
      return s;
   endfunction

   function automatic int rnd8();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NE; i++) bank_m[i] = 0;
      for (int k = 0; k < NP; k++) acc_m[k] = 0;
      cnt_m = 0; last_hit_cyc = -100; last_fin_cyc = -100;
      err_m = 0; rd_pend = 0; busy_snap = 0;
      exp_q.delete();
   endtask

   // Advance one cycle, idle the inputs, and compare busy/cfg_err/read port with the model.
   task automatic tick();
      @(posedge clk); #1;
      dv_in = 1'b0; mem_en = 1'b0; mem_rd_wr = 1'b0;
      busy_snap = (cnt_m != 0) || (cyc <= last_hit_cyc + 2) || (cyc <= last_fin_cyc + 2 + NP);
      chk("busy", busy, busy_snap);
      chk("cfg_err", cfg_err, err_m);
      if (rd_pend) begin
         chk("rvalid", mem_rvalid, 1);
         chk("rdata", mem_rdata, rd_exp);
         rd_pend = 0;
      end else begin
         chk("rvalid_idle", mem_rvalid, 0);
      end
   endtask

   task automatic drive_write(input int a, input longint v);
      mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = AW'(a); mem_data = KW'(v);
      if (!busy_snap && a < NE) bank_m[a] = v;
      else err_m = 1;
   endtask

   task automatic drive_read(input int a);
      mem_en = 1'b1; mem_rd_wr = 1'b0; mem_add = AW'(a);
      rd_pend = 1;
      rd_exp = '0;
      if (a < NE) rd_exp = KW'(bank_m[a]);
   endtask

   // Each hit adds its dot product using the coefficients present when it is sampled.
   task automatic drive_hit(input int x, input int y, input int z);
      dv_in = 1'b1; data_in_x = CW'(x); data_in_y = CW'(y); data_in_z = CW'(z);
      for (int k = 0; k < NP; k++) begin
         if (cnt_m == 0) acc_m[k] = bank_m[offset_addr(k, NL)];
         acc_m[k] += x * bank_m[coef_addr(k, cnt_m, AX_X, NL)]
                   + y * bank_m[coef_addr(k, cnt_m, AX_Y, NL)]
                   + z * bank_m[coef_addr(k, cnt_m, AX_Z, NL)];
      end
      last_hit_cyc = cyc;
      cnt_m++;
      if (cnt_m == NL) begin
         for (int k = 0; k < NP; k++) exp_q.push_back('{cyc + 3 + k, k, sat_m(acc_m[k])});
         last_fin_cyc = cyc;
         cnt_m = 0;
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < n; i++) begin
         chk("rst_dv_out", dv_out, 0);
         chk("rst_data_out", data_out, 0);
         chk("rst_param_idx", param_idx, 0);
         chk("rst_busy", busy, 0);
         chk("rst_cfg_err", cfg_err, 0);
         chk("rst_rdata", mem_rdata, 0);
         chk("rst_rvalid", mem_rvalid, 0);
         dv_in = 1'($urandom); data_in_x = CW'($urandom); data_in_y = CW'($urandom);
         data_in_z = CW'($urandom); mem_en = 1'($urandom); mem_rd_wr = 1'($urandom);
         mem_add = AW'($urandom); mem_data = KW'($urandom);
         @(posedge clk); #1;
      end
      dv_in = 1'b0; mem_en = 1'b0; mem_rd_wr = 1'b0;
      reset = 1'b1;
      tick();
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || busy_snap) && n < 40) begin
         tick();
         n++;
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic load_random();
      for (int a = 0; a < NE; a++) begin
         drive_write(a, rnd8());
         tick();
      end
   endtask

   task automatic send_track(input int gap_max);
      for (int l = 0; l < NL; l++) begin
         repeat ($urandom_range(0, gap_max)) tick();
         drive_hit(rnd8(), rnd8(), rnd8());
         tick();
      end
   endtask

   // Every cycle: dv_out must be high exactly when a result is due, carrying the model's value.
   always @(negedge clk) begin
      if (exp_q.size() != 0 && exp_q[0].c == cyc) begin
         e = exp_q.pop_front();
         chk("dv_out", dv_out, 1);
         chk("data_out", data_out, e.v);
         chk("param_idx", param_idx, e.k);
      end else begin
         chk("dv_out_idle", dv_out, 0);
      end
   end

   initial begin
      // Reset with random input activity, then every address reads back zero
      do_reset(8);
      for (int i = 0; i < 6; i++) begin
         drive_read($urandom_range(0, NE - 1));
         tick();
      end
      tick();

      // Basic fit: cx=1 on parameter 0, offset_1=5, x=1..6 -> 21 then 5
      for (int l = 0; l < NL; l++) begin
         drive_write(coef_addr(0, l, AX_X, NL), 1);
         tick();
      end
      drive_write(offset_addr(1, NL), 5);
      tick();
      for (int l = 0; l < NL; l++) begin
         drive_hit(l + 1, rnd8(), rnd8());
         tick();
      end
      wait_idle();
      // Same fit with random gaps, then two tracks back to back
      for (int l = 0; l < NL; l++) begin
         repeat ($urandom_range(0, 3)) tick();
         drive_hit(l + 1, rnd8(), rnd8());
         tick();
      end
      for (int t = 0; t < 2; t++)
         for (int l = 0; l < NL; l++) begin
            drive_hit(l + 1, rnd8(), rnd8());
            tick();
         end
      wait_idle();

      // Saturation both ways: cx=127 on p0, cx=-128 on p1, x=127
      for (int l = 0; l < NL; l++) begin
         drive_write(coef_addr(0, l, AX_X, NL), 127);
         tick();
         drive_write(coef_addr(1, l, AX_X, NL), -128);
         tick();
      end
      for (int l = 0; l < NL; l++) begin
         drive_hit(127, rnd8(), rnd8());
         tick();
      end
      wait_idle();

      // Random coefficients and hits, mixed gaps and back-to-back tracks
      load_random();
      for (int t = 0; t < 4; t++) send_track((t % 2 == 0) ? 0 : 2);
      wait_idle();

      // Write while a track is in flight: rejected, sticky error, result unaffected
      do_reset(2);
      load_random();
      for (int l = 0; l < 2; l++) begin
         drive_hit(rnd8(), rnd8(), rnd8());
         tick();
      end
      drive_write(coef_addr(0, 3, AX_Y, NL), 77);
      tick();
      for (int l = 2; l < NL; l++) begin
         drive_hit(rnd8(), rnd8(), rnd8());
         tick();
      end
      wait_idle();
      drive_read(coef_addr(0, 3, AX_Y, NL));
      tick();

      // Out-of-range access: read returns 0 without error, write sets the error
      do_reset(2);
      drive_write(0, 42);
      tick();
      drive_read(NE);
      tick();
      drive_read(0);
      tick();
      drive_write(NE, 9);
      tick();
      tick();

      // Write coinciding with the first hit of an idle fitter: accepted, hit sees the old value
      do_reset(2);
      load_random();
      tick();
      begin
         int a0 = coef_addr(0, 0, AX_X, NL);
         longint nv = (bank_m[a0] == 100) ? -100 : 100;
         drive_hit(50, rnd8(), rnd8());
         drive_write(a0, nv);
         tick();
         for (int l = 1; l < NL; l++) begin
            drive_hit(rnd8(), rnd8(), rnd8());
            tick();
         end
         wait_idle();
         drive_read(a0);
         tick();
         send_track(0);
         wait_idle();
      end

      // Reset after three hits: no stale output, bank cleared, next track fits cleanly
      load_random();
      for (int l = 0; l < 3; l++) begin
         drive_hit(rnd8(), rnd8(), rnd8());
         tick();
      end
      do_reset(3);
      drive_read(coef_addr(1, 2, AX_Z, NL));
      tick();
      load_random();
      send_track(0);
      wait_idle();
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
